// File: rtl/msdf_test_initiator.sv
// msdf_test_initiator
//   Avalon-MM master that runs one complete MSDF test on a test control unit.
//   On an accepted start it checks the slave ID, programs the start address and
//   the element count, reads the count back, sets go, then polls the status
//   register until go clears or the poll budget runs out.
//
// Ports
//   avalon_clock            clock shared with the slave
//   resetn                  synchronous, active-low reset
//   start                   one-cycle run request (ignored while busy)
//   cfg_set_addr, cfg_num   run configuration, latched on an accepted start
//   address/writedata/write/read/readdata   Avalon-MM master port
//   busy, done, error, err_code, poll_count run status
module msdf_test_initiator #(
  parameter int ADDR_WIDTH  = 11,
  parameter int ID_EXPECTED = 1,
  parameter int TIMEOUT_W   = 20,
  parameter int POLL_GAP    = 4
) (
  input  logic                  avalon_clock,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_set_addr,
  input  logic [ADDR_WIDTH:0]   cfg_num,
  output logic [2:0]            address,
  output logic [31:0]           writedata,
  output logic                  write,
  output logic                  read,
  input  logic [31:0]           readdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [TIMEOUT_W-1:0]  poll_count
);

  typedef enum logic [3:0] {
    IDLE, RD_ID, CK_ID, WR_ADDR, WR_NUM, RD_NUM, CK_NUM,
    WR_GO, GAP, RD_ST, CK_ST, FIN
  } state_t;

  localparam logic [31:0] ID_WORD  = 32'(ID_EXPECTED);
  localparam logic [3:0]  GAP_LAST = 4'((POLL_GAP > 0) ? (POLL_GAP - 1) : 0);
  // With no idle gap configured, polling goes straight to the status read.
  localparam state_t      POLL_ENTRY = (POLL_GAP == 0) ? RD_ST : GAP;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] set_addr_reg, set_addr_next;
  logic [ADDR_WIDTH:0]   num_reg, num_next;
  logic [3:0]            gap_cnt_reg, gap_cnt_next;
  logic [TIMEOUT_W-1:0]  poll_cnt_reg, poll_cnt_next;
  logic [1:0]            err_code_reg, err_code_next;
  logic                  error_reg, error_next;
  logic [2:0]            address_reg, address_next;
  logic [31:0]           writedata_reg, writedata_next;
  logic                  write_reg, write_next;
  logic                  read_reg, read_next;
  logic                  busy_reg, busy_next;
  logic                  done_reg, done_next;

  always_comb begin
    state_next     = state_reg;
    set_addr_next  = set_addr_reg;
    num_next       = num_reg;
    gap_cnt_next   = gap_cnt_reg;
    poll_cnt_next  = poll_cnt_reg;
    err_code_next  = err_code_reg;
    error_next     = error_reg;
    address_next   = 3'd0;
    writedata_next = 32'd0;
    write_next     = 1'b0;
    read_next      = 1'b0;
    done_next      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next    = RD_ID;
          set_addr_next = cfg_set_addr;
          num_next      = cfg_num;
          error_next    = 1'b0;
          err_code_next = 2'b00;
          poll_cnt_next = '0;
        end
      end
      RD_ID:   state_next = CK_ID;
      CK_ID: begin
        if (readdata != ID_WORD) begin
          err_code_next = 2'b01;
          state_next    = FIN;
        end else begin
          state_next = WR_ADDR;
        end
      end
      WR_ADDR: state_next = WR_NUM;
      WR_NUM:  state_next = RD_NUM;
      RD_NUM:  state_next = CK_NUM;
      CK_NUM: begin
        if (readdata[ADDR_WIDTH:0] != num_reg) begin
          err_code_next = 2'b10;
          state_next    = FIN;
        end else begin
          state_next = WR_GO;
        end
      end
      WR_GO: begin
        state_next   = POLL_ENTRY;
        gap_cnt_next = 4'd0;
      end
      GAP: begin
        if (gap_cnt_reg == GAP_LAST) begin
          state_next = RD_ST;
        end else begin
          gap_cnt_next = gap_cnt_reg + 4'd1;
        end
      end
      RD_ST:   state_next = CK_ST;
      CK_ST: begin
        if (!readdata[0]) begin
          state_next = FIN;
        end else if (&poll_cnt_reg) begin
          err_code_next = 2'b11;
          state_next    = FIN;
        end else begin
          state_next   = POLL_ENTRY;
          gap_cnt_next = 4'd0;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // Bus and status outputs are decoded from the state being entered so that
    // the registered strobes line up with the state they belong to.
    case (state_next)
      RD_ID: begin
        read_next    = 1'b1;
        address_next = 3'd3;
      end
      WR_ADDR: begin
        write_next     = 1'b1;
        address_next   = 3'd1;
        writedata_next = 32'(set_addr_next);
      end
      WR_NUM: begin
        write_next     = 1'b1;
        address_next   = 3'd2;
        writedata_next = 32'(num_next);
      end
      RD_NUM: begin
        read_next    = 1'b1;
        address_next = 3'd2;
      end
      WR_GO: begin
        write_next     = 1'b1;
        address_next   = 3'd0;
        writedata_next = 32'd1;
      end
      RD_ST: begin
        read_next     = 1'b1;
        address_next  = 3'd0;
        poll_cnt_next = poll_cnt_reg + 1'b1;
      end
      FIN: begin
        done_next  = 1'b1;
        error_next = (err_code_next != 2'b00);
      end
      default: ;
    endcase

    busy_next = (state_next != IDLE) && (state_next != FIN);
  end

  always_ff @(posedge avalon_clock) begin
    if (!resetn) begin
      state_reg     <= IDLE;
      set_addr_reg  <= '0;
      num_reg       <= '0;
      gap_cnt_reg   <= 4'd0;
      poll_cnt_reg  <= '0;
      err_code_reg  <= 2'b00;
      error_reg     <= 1'b0;
      address_reg   <= 3'd0;
      writedata_reg <= 32'd0;
      write_reg     <= 1'b0;
      read_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      set_addr_reg  <= set_addr_next;
      num_reg       <= num_next;
      gap_cnt_reg   <= gap_cnt_next;
      poll_cnt_reg  <= poll_cnt_next;
      err_code_reg  <= err_code_next;
      error_reg     <= error_next;
      address_reg   <= address_next;
      writedata_reg <= writedata_next;
      write_reg     <= write_next;
      read_reg      <= read_next;
      busy_reg      <= busy_next;
      done_reg      <= done_next;
    end
  end

  assign address    = address_reg;
  assign writedata  = writedata_reg;
  assign write      = write_reg;
  assign read       = read_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;
  assign error      = error_reg;
  assign err_code   = err_code_reg;
  assign poll_count = poll_cnt_reg;

endmodule

// File: tb/tb_msdf_test_initiator.sv
// tb_msdf_test_initiator
//   Directed bench for msdf_test_initiator with a behavioural model of the
//   MSDF test control unit's register map (0 go/status, 1 address, 2 count,
//   3 ID) answering with one cycle of read latency.
module tb_msdf_test_initiator;
  localparam int AW = 11;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          resetn, start;
  logic [AW-1:0] cfg_set_addr;
  logic [AW:0]   cfg_num;
  logic [2:0]    address;
  logic [31:0]   writedata, readdata;
  logic          write, read, busy, done, error;
  logic [1:0]    err_code;
  logic [TW-1:0] poll_count;

  always #5 clk = ~clk;

  msdf_test_initiator #(
    .ADDR_WIDTH(AW), .ID_EXPECTED(1), .TIMEOUT_W(TW), .POLL_GAP(4)
  ) dut (
    .avalon_clock(clk), .resetn(resetn), .start(start),
    .cfg_set_addr(cfg_set_addr), .cfg_num(cfg_num),
    .address(address), .writedata(writedata), .write(write), .read(read),
    .readdata(readdata), .busy(busy), .done(done), .error(error),
    .err_code(err_code), .poll_count(poll_count)
  );

  int total = 0;
  int bad   = 0;

  // Slave behaviour knobs (written only by the test tasks)
  logic [31:0] id_val;
  logic [31:0] num_xor;
  int          go_delay;
  bit          never_clear;

  // Slave model state
  logic        s_go;
  logic [31:0] s_addr, s_num;
  int          go_timer;

  always @(posedge clk) begin
    if (!resetn) begin
      s_go <= 1'b0; s_addr <= 32'd0; s_num <= 32'd0; go_timer <= 0; readdata <= 32'd0;
    end else begin
      if (write) begin
        case (address)
          3'd0: begin s_go <= writedata[0]; go_timer <= 0; end
          3'd1: s_addr <= writedata;
          3'd2: s_num <= writedata;
          default: ;
        endcase
      end else if (s_go) begin
        if (!never_clear && (go_timer + 1 >= go_delay)) s_go <= 1'b0;
        go_timer <= go_timer + 1;
      end
      if (read) begin
        case (address)
          3'd0: readdata <= {31'd0, s_go};
          3'd1: readdata <= s_addr;
          3'd2: readdata <= s_num ^ num_xor;
          3'd3: readdata <= id_val;
          default: readdata <= 32'd0;
        endcase
      end
    end
  end

  // Bus monitor
  typedef struct { logic [2:0] a; logic [31:0] d; } wr_t;
  wr_t wr_log[$];
  int  rd0_cnt   = 0;
  int  clash_cnt = 0;

  always @(negedge clk) begin
    if (write) wr_log.push_back('{a: address, d: writedata});
    if (read && address == 3'd0) rd0_cnt++;
    if (read && write) clash_cnt++;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Pulse start, wait (bounded) for done, capture status, then idle one cycle.
  task automatic run(input logic [AW-1:0] sa, input logic [AW:0] n,
                     output logic [1:0] ec, output logic er, output logic [TW-1:0] pc,
                     output logic bz, output int cyc, output bit seen);
    ec = 2'bxx; er = 1'bx; pc = 'x; bz = 1'bx; cyc = 0; seen = 0;
    cfg_set_addr = sa; cfg_num = n; start = 1'b1;
    tick;
    start = 1'b0;
    while (!seen && cyc < 400) begin
      tick;
      cyc++;
      if (done) begin
        seen = 1; ec = err_code; er = error; pc = poll_count; bz = busy;
      end
    end
    $display("run sa=%0d num=%0d err_code=%b error=%b polls=%0d cycles=%0d done_seen=%0d",
             sa, n, ec, er, pc, cyc, seen);
    tick;
  endtask

  task automatic test_reset;
    resetn = 1'b0; tick; tick;
    total++; if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
      bad++; $display("FAIL reset_status got busy=%b done=%b error=%b want 0 0 0", busy, done, error);
    end
    total++; if (read !== 1'b0 || write !== 1'b0 || address !== 3'd0 || writedata !== 32'd0) begin
      bad++; $display("FAIL reset_bus got rd=%b wr=%b a=%0d d=%h want 0 0 0 0", read, write, address, writedata);
    end
    total++; if (err_code !== 2'b00 || poll_count !== 4'd0) begin
      bad++; $display("FAIL reset_counters got ec=%b pc=%0d want 00 0", err_code, poll_count);
    end
    resetn = 1'b1; tick;
  endtask

  task automatic test_nominal;
    logic [1:0] ec; logic er, bz; logic [TW-1:0] pc; int cyc, base; bit seen;
    id_val = 32'd1; num_xor = 32'd0; go_delay = 20; never_clear = 0;
    base = wr_log.size();
    run(11'd0, 12'd8, ec, er, pc, bz, cyc, seen);
    total++; if (!seen) begin bad++; $display("FAIL nominal_done got none within %0d cycles want pulse", cyc); end
    total++; if (ec !== 2'b00 || er !== 1'b0) begin
      bad++; $display("FAIL nominal_result got ec=%b er=%b want 00 0", ec, er);
    end
    total++; if (pc < 3 || pc > 5) begin bad++; $display("FAIL nominal_polls got %0d want 3..5", pc); end
    total++; if (bz !== 1'b0) begin bad++; $display("FAIL nominal_busy_at_done got %b want 0", bz); end
    total++; if (wr_log.size() - base != 3) begin
      bad++; $display("FAIL nominal_write_count got %0d want 3", wr_log.size() - base);
    end else if (wr_log[base].a !== 3'd1 || wr_log[base].d !== 32'd0 ||
                 wr_log[base+1].a !== 3'd2 || wr_log[base+1].d !== 32'd8 ||
                 wr_log[base+2].a !== 3'd0 || wr_log[base+2].d !== 32'd1) begin
      bad++; $display("FAIL nominal_write_seq got (%0d,%h)(%0d,%h)(%0d,%h) want (1,0)(2,8)(0,1)",
                      wr_log[base].a, wr_log[base].d, wr_log[base+1].a, wr_log[base+1].d,
                      wr_log[base+2].a, wr_log[base+2].d);
    end
    total++; if (done !== 1'b0 || busy !== 1'b0 || address !== 3'd0 || writedata !== 32'd0) begin
      bad++; $display("FAIL nominal_after_fin got done=%b busy=%b a=%0d d=%h want 0 0 0 0",
                      done, busy, address, writedata);
    end
  endtask

  task automatic test_id_mismatch;
    logic [1:0] ec; logic er, bz; logic [TW-1:0] pc; int cyc, base; bit seen;
    id_val = 32'd7;
    base = wr_log.size();
    run(11'd0, 12'd8, ec, er, pc, bz, cyc, seen);
    total++; if (!seen || cyc > 5) begin
      bad++; $display("FAIL id_done_latency got seen=%0d cycles=%0d want done within 5", seen, cyc);
    end
    total++; if (ec !== 2'b01 || er !== 1'b1) begin
      bad++; $display("FAIL id_result got ec=%b er=%b want 01 1", ec, er);
    end
    total++; if (wr_log.size() != base) begin
      bad++; $display("FAIL id_no_writes got %0d writes want 0", wr_log.size() - base);
    end
    id_val = 32'd1;
  endtask

  task automatic test_count_mismatch;
    logic [1:0] ec; logic er, bz; logic [TW-1:0] pc; int cyc, base; bit seen;
    num_xor = 32'd1;
    base = wr_log.size();
    run(11'd3, 12'd10, ec, er, pc, bz, cyc, seen);
    total++; if (ec !== 2'b10 || er !== 1'b1) begin
      bad++; $display("FAIL cnt_result got ec=%b er=%b want 10 1", ec, er);
    end
    total++; if (wr_log.size() - base != 2 || wr_log[base].a !== 3'd1 || wr_log[base+1].a !== 3'd2) begin
      bad++; $display("FAIL cnt_writes got n=%0d want 2 writes to addr 1 then 2", wr_log.size() - base);
    end
    num_xor = 32'd0;
  endtask

  task automatic test_timeout;
    logic [1:0] ec; logic er, bz; logic [TW-1:0] pc; int cyc, rbase; bit seen;
    never_clear = 1;
    rbase = rd0_cnt;
    run(11'd0, 12'd8, ec, er, pc, bz, cyc, seen);
    total++; if (!seen || ec !== 2'b11 || er !== 1'b1) begin
      bad++; $display("FAIL timeout_result got seen=%0d ec=%b er=%b want 1 11 1", seen, ec, er);
    end
    total++; if (rd0_cnt - rbase != 15) begin
      bad++; $display("FAIL timeout_status_reads got %0d want 15", rd0_cnt - rbase);
    end
    total++; if (pc !== 4'd15) begin bad++; $display("FAIL timeout_poll_count got %0d want 15", pc); end
    never_clear = 0;
  endtask

  task automatic test_immediate;
    int cyc, base; bit seen;
    logic [1:0] ec; logic er; logic [TW-1:0] pc;
    go_delay = 1;
    base = wr_log.size();
    cfg_set_addr = 11'd5; cfg_num = 12'd5; start = 1'b1;
    tick;
    // second request while busy with different configuration
    cfg_set_addr = 11'd9; cfg_num = 12'd33;
    tick;
    start = 1'b0;
    seen = 0; cyc = 0; ec = 2'bxx; er = 1'bx; pc = 'x;
    while (!seen && cyc < 400) begin
      tick; cyc++;
      if (done) begin seen = 1; ec = err_code; er = error; pc = poll_count; end
    end
    $display("run sa=5 num=5 (start during busy) err_code=%b error=%b polls=%0d cycles=%0d", ec, er, pc, cyc);
    total++; if (!seen || ec !== 2'b00 || er !== 1'b0 || pc !== 4'd1) begin
      bad++; $display("FAIL immediate_result got seen=%0d ec=%b er=%b pc=%0d want 1 00 0 1", seen, ec, er, pc);
    end
    total++; if (wr_log.size() - base != 3 || wr_log[base].d !== 32'd5 || wr_log[base+1].d !== 32'd5) begin
      bad++; $display("FAIL immediate_cfg_kept got n=%0d addr=%h num=%h want 3 5 5",
                      wr_log.size() - base, wr_log[base].d, wr_log[base+1].d);
    end
    tick; tick; tick;
    total++; if (busy !== 1'b0 || wr_log.size() - base != 3) begin
      bad++; $display("FAIL immediate_no_rerun got busy=%b writes=%0d want 0 3", busy, wr_log.size() - base);
    end
    go_delay = 20;
  endtask

  task automatic test_full_width_num;
    logic [1:0] ec; logic er, bz; logic [TW-1:0] pc; int cyc, base; bit seen;
    base = wr_log.size();
    run(11'h7FF, 12'h800, ec, er, pc, bz, cyc, seen);
    total++; if (wr_log[base].d !== 32'h7FF || wr_log[base+1].d !== 32'h800) begin
      bad++; $display("FAIL wide_writes got addr=%h num=%h want 7ff 800", wr_log[base].d, wr_log[base+1].d);
    end
    total++; if (!seen || ec !== 2'b00 || er !== 1'b0) begin
      bad++; $display("FAIL wide_result got seen=%0d ec=%b er=%b want 1 00 0", seen, ec, er);
    end
  endtask

  task automatic test_reset_midrun;
    logic [1:0] ec; logic er, bz; logic [TW-1:0] pc; int cyc; bit seen;
    cfg_set_addr = 11'd0; cfg_num = 12'd8; start = 1'b1;
    tick;
    start = 1'b0;
    cyc = 0;
    while (!(write && address == 3'd0) && cyc < 50) begin tick; cyc++; end
    total++; if (cyc >= 50) begin bad++; $display("FAIL midrun_go_write got none want go write"); end
    tick; tick;                       // now inside the poll gap
    resetn = 1'b0;
    tick;
    $display("reset during gap busy=%b read=%b write=%b err_code=%b", busy, read, write, err_code);
    total++; if (busy !== 1'b0 || read !== 1'b0 || write !== 1'b0 || err_code !== 2'b00) begin
      bad++; $display("FAIL midrun_reset got busy=%b rd=%b wr=%b ec=%b want 0 0 0 00", busy, read, write, err_code);
    end
    resetn = 1'b1;
    tick;
    run(11'd0, 12'd8, ec, er, pc, bz, cyc, seen);
    total++; if (!seen || ec !== 2'b00 || er !== 1'b0) begin
      bad++; $display("FAIL midrun_rerun got seen=%0d ec=%b er=%b want 1 00 0", seen, ec, er);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b0; cfg_set_addr = '0; cfg_num = '0;
    id_val = 32'd1; num_xor = 32'd0; go_delay = 20; never_clear = 0;
    test_reset;
    test_nominal;
    test_id_mismatch;
    test_count_mismatch;
    test_timeout;
    test_immediate;
    test_full_width_num;
    test_reset_midrun;
    total++; if (clash_cnt != 0) begin
      bad++; $display("FAIL read_write_overlap got %0d cycles want 0", clash_cnt);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
